// File: rtl/spi_sd_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_sd_cmd_sequencer
//
// Runs one SD-card SPI-mode command transaction on top of a byte-level SPI
// master engine:
//   chip select low -> 6-byte command frame -> 0xFF polls until an R1 byte
//   (MSB clear) or MAX_POLL polls -> one trailing 0xFF -> chip select high.
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | waiting for cmd_valid; cmd_ready=1, ss_n=1
//   CMD_ISSUE   | spi_start for frame byte byte_cnt
//   CMD_WAIT    | waiting for spi_done of a frame byte (spi_rx ignored)
//   POLL_ISSUE  | spi_start for a 0xFF poll byte
//   POLL_WAIT   | waiting for spi_done of a poll byte; check for R1
//   TRAIL_ISSUE | spi_start for the trailing 0xFF byte
//   TRAIL_WAIT  | waiting for spi_done of the trailing byte (spi_rx dropped)
//   DONE        | ss_n=1, resp_valid pulse, back to IDLE
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake from the SD driver register block
//   cmd_index/arg/crc   command fields, sampled at accept
//   resp_valid          one-cycle completion pulse
//   resp_r1             R1 byte (0xFF on timeout), held until the next result
//   resp_timeout        set when no R1 arrived within MAX_POLL polls
//   spi_start/spi_tx    byte request to the SPI engine
//   spi_done/spi_rx     byte completion and MISO byte from the SPI engine
//   ss_n                SD chip select, active low
// -----------------------------------------------------------------------------
module spi_sd_cmd_sequencer #(
  parameter int MAX_POLL = 8,
  parameter int POLL_W   = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,

  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,

  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,

  output logic        ss_n
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CMD_ISSUE   = 3'd1,
    ST_CMD_WAIT    = 3'd2,
    ST_POLL_ISSUE  = 3'd3,
    ST_POLL_WAIT   = 3'd4,
    ST_TRAIL_ISSUE = 3'd5,
    ST_TRAIL_WAIT  = 3'd6,
    ST_DONE        = 3'd7
  } state_t;

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(MAX_POLL - 1);
  localparam logic [2:0]        FRAME_LAST = 3'd5;
  localparam logic [7:0]        IDLE_BYTE  = 8'hFF;

  state_t             state_q,        state_d;
  logic [47:0]        frame_q,        frame_d;
  logic [2:0]         byte_cnt_q,     byte_cnt_d;
  logic [POLL_W-1:0]  poll_cnt_q,     poll_cnt_d;
  logic [7:0]         resp_r1_q,      resp_r1_d;
  logic               resp_timeout_q, resp_timeout_d;
  logic               ss_n_q,         ss_n_d;

  logic [7:0]         frame_byte;
  logic               in_frame;

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      byte_cnt_q     <= '0;
      poll_cnt_q     <= '0;
      resp_r1_q      <= 8'hFF;
      resp_timeout_q <= 1'b0;
      ss_n_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      byte_cnt_q     <= byte_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      resp_r1_q      <= resp_r1_d;
      resp_timeout_q <= resp_timeout_d;
      ss_n_q         <= ss_n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame byte select, MSB-first
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_byte = frame_q[7:0];
    case (byte_cnt_q)
      3'd0:    frame_byte = frame_q[47:40];
      3'd1:    frame_byte = frame_q[39:32];
      3'd2:    frame_byte = frame_q[31:24];
      3'd3:    frame_byte = frame_q[23:16];
      3'd4:    frame_byte = frame_q[15:8];
      default: frame_byte = frame_q[7:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    byte_cnt_d     = byte_cnt_q;
    poll_cnt_d     = poll_cnt_q;
    resp_r1_d      = resp_r1_q;
    resp_timeout_d = resp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d    = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
          byte_cnt_d = '0;
          poll_cnt_d = '0;
          state_d    = ST_CMD_ISSUE;
        end
      end

      ST_CMD_ISSUE: state_d = ST_CMD_WAIT;

      ST_CMD_WAIT: begin
        if (spi_done) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == FRAME_LAST) begin
            poll_cnt_d = '0;
            state_d    = ST_POLL_ISSUE;
          end else begin
            state_d    = ST_CMD_ISSUE;
          end
        end
      end

      ST_POLL_ISSUE: state_d = ST_POLL_WAIT;

      ST_POLL_WAIT: begin
        if (spi_done) begin
          if (!spi_rx[7]) begin
            resp_r1_d      = spi_rx;
            resp_timeout_d = 1'b0;
            state_d        = ST_TRAIL_ISSUE;
          end else if (poll_cnt_q == POLL_LAST) begin
            resp_r1_d      = 8'hFF;
            resp_timeout_d = 1'b1;
            state_d        = ST_TRAIL_ISSUE;
          end else begin
            poll_cnt_d     = poll_cnt_q + 1'b1;
            state_d        = ST_POLL_ISSUE;
          end
        end
      end

      ST_TRAIL_ISSUE: state_d = ST_TRAIL_WAIT;

      ST_TRAIL_WAIT: begin
        if (spi_done) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Chip select is registered from the next state so the pad sees a clean
  // flop output: low from the cycle after accept, high again in DONE, and no
  // decode glitches between bytes.
  always_comb begin
    ss_n_d = 1'b0;
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      ss_n_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // spi_tx follows the frame counter through both ISSUE and WAIT so the byte
  // is stable for the whole time the engine holds it; byte_cnt only moves on
  // spi_done.
  assign in_frame     = (state_q == ST_CMD_ISSUE) || (state_q == ST_CMD_WAIT);
  assign spi_tx       = in_frame ? frame_byte : IDLE_BYTE;
  assign spi_start    = (state_q == ST_CMD_ISSUE) ||
                        (state_q == ST_POLL_ISSUE) ||
                        (state_q == ST_TRAIL_ISSUE);
  assign cmd_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_DONE);
  assign resp_r1      = resp_r1_q;
  assign resp_timeout = resp_timeout_q;
  assign ss_n         = ss_n_q;

endmodule
